// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD write controller.
// Supports an 8-bit or 4-bit bus, row/column cursor addressing with range
// checking, a valid/ready request port, and optional power-on initialisation.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | waiting for a request (o_ready may be high)
// PWR_WAIT    | power-on settle before the init sequence
// SETUP       | RS and data driven, E low
// E_HIGH      | enable pulse high
// E_LOW       | enable low, RS and data still held
// EXEC_WAIT   | inter-nibble gap or the byte's execution time
// SEQ         | fetch the next init-sequence byte
// DONE        | one-cycle completion pulse (o_done, optionally o_err)

module lcd_hd44780_ctrl #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BUS_WIDTH = 8,
  parameter int NUM_ROWS  = 2,
  parameter int NUM_COLS  = 16,
  parameter int AUTO_INIT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [1:0] i_op,
  input  logic [7:0] i_data,
  input  logic [1:0] i_row,
  input  logic [5:0] i_col,
  output logic       o_done,
  output logic       o_err,
  output logic       o_init_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_e,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_on,
  output logic       o_lcd_blon
);

  // ceil(CLK_FREQ * t), never less than one cycle
  function automatic logic [31:0] ns_to_cyc(input longint t_ns);
    longint c;
    c = (longint'(CLK_FREQ) * t_ns + 64'sd999_999_999) / 64'sd1_000_000_000;
    if (c < 64'sd1) c = 64'sd1;
    return c[31:0];
  endfunction

  localparam logic [31:0] C_E    = ns_to_cyc(500);
  localparam logic [31:0] C_NIB  = ns_to_cyc(1_000);
  localparam logic [31:0] C_EXEC = ns_to_cyc(37_000);
  localparam logic [31:0] C_100  = ns_to_cyc(100_000);
  localparam logic [31:0] C_CLR  = ns_to_cyc(1_520_000);
  localparam logic [31:0] C_4100 = ns_to_cyc(4_100_000);
  localparam logic [31:0] C_PWR  = ns_to_cyc(15_000_000);

  // function set: DL follows the bus width, N bit dropped on one-row panels
  localparam logic [7:0] C_FUNC = (BUS_WIDTH == 4 ? 8'h28 : 8'h38) &
                                  (NUM_ROWS == 1 ? 8'hF7 : 8'hFF);

  localparam logic [1:0] OP_INIT = 2'd0;
  localparam logic [1:0] OP_SETC = 2'd1;
  localparam logic [1:0] OP_DATA = 2'd2;

  localparam logic [3:0] STEP_END = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE, S_PWR_WAIT, S_SETUP, S_E_HIGH, S_E_LOW, S_EXEC_WAIT, S_SEQ, S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, r_exec, w_exec_nxt, w_delay, w_seq_delay;
  logic [7:0]  r_byte, w_byte_nxt, w_seq_byte, w_base, w_addr;
  logic [3:0]  r_step, w_step_nxt, w_step_inc;
  logic        r_rs, w_rs_nxt, r_nib, w_nib_nxt, r_single, w_single_nxt;
  logic        r_init, w_init_nxt, r_err, w_err_nxt;
  logic        r_init_done, w_init_done_nxt, r_blon, w_blon_nxt, r_ready;
  logic        w_seq_single, w_accept, w_cnt_done, w_gap, w_pos_bad;
  logic [3:0]  w_nibble;

  assign w_accept   = i_valid && r_ready;
  assign w_gap      = (BUS_WIDTH == 4) && !r_single && !r_nib;
  assign w_cnt_done = (r_cnt == w_delay - 32'd1);
  assign w_step_inc = (BUS_WIDTH != 4 && r_step == 4'd2) ? 4'd4 : r_step + 4'd1;
  assign w_pos_bad  = ({1'b0, i_row} >= 3'(NUM_ROWS)) || (i_col >= 6'(NUM_COLS));
  assign w_addr     = w_base + {2'b00, i_col};

  // DDRAM row base address for cursor positioning
  always_comb begin
    w_base = 8'h00;
    case (i_row)
      2'd1:    w_base = 8'h40;
      2'd2:    w_base = 8'(NUM_COLS);
      2'd3:    w_base = 8'h40 + 8'(NUM_COLS);
      default: w_base = 8'h00;
    endcase
  end

  // init sequence table; step 3 (the 4-bit switch nibble) is skipped on an 8-bit bus
  always_comb begin
    w_seq_byte   = 8'h00;
    w_seq_single = 1'b0;
    w_seq_delay  = C_EXEC;
    case (r_step)
      4'd0:       begin w_seq_byte = 8'h30; w_seq_single = 1'b1; w_seq_delay = C_4100; end
      4'd1, 4'd2: begin w_seq_byte = 8'h30; w_seq_single = 1'b1; w_seq_delay = C_100;  end
      4'd3:       begin w_seq_byte = 8'h20; w_seq_single = 1'b1; end
      4'd4:       w_seq_byte = C_FUNC;
      4'd5:       w_seq_byte = 8'h08;
      4'd6:       begin w_seq_byte = 8'h01; w_seq_delay = C_CLR; end
      4'd7:       w_seq_byte = 8'h06;
      4'd8:       w_seq_byte = 8'h0C;
      default:    w_seq_byte = 8'h00;
    endcase
  end

  // length of the current state in cycles
  always_comb begin
    w_delay = 32'd1;
    case (r_state)
      S_PWR_WAIT:                  w_delay = C_PWR;
      S_SETUP, S_E_HIGH, S_E_LOW:  w_delay = C_E;
      S_EXEC_WAIT:                 w_delay = w_gap ? C_NIB : r_exec;
      default:                     w_delay = 32'd1;
    endcase
  end

  // next-state and datapath-load decisions
  always_comb begin
    w_state_nxt     = r_state;
    w_byte_nxt      = r_byte;
    w_rs_nxt        = r_rs;
    w_nib_nxt       = r_nib;
    w_single_nxt    = r_single;
    w_exec_nxt      = r_exec;
    w_init_nxt      = r_init;
    w_step_nxt      = r_step;
    w_err_nxt       = r_err;
    w_init_done_nxt = r_init_done;
    w_blon_nxt      = r_blon;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_err_nxt    = 1'b0;
          w_nib_nxt    = 1'b0;
          w_single_nxt = 1'b0;
          w_init_nxt   = 1'b0;
          w_exec_nxt   = C_EXEC;
          if (i_op == OP_INIT) begin
            w_init_nxt      = 1'b1;
            w_init_done_nxt = 1'b0;
            w_step_nxt      = 4'd0;
            w_state_nxt     = S_PWR_WAIT;
          end else if (!r_init_done || (i_op == OP_SETC && w_pos_bad)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SETUP;
            w_rs_nxt    = (i_op == OP_DATA);
            w_byte_nxt  = (i_op == OP_SETC) ? (8'h80 | w_addr) : i_data;
            if (i_op != OP_DATA && i_op != OP_SETC &&
                (i_data == 8'h01 || i_data == 8'h02))
              w_exec_nxt = C_CLR;
          end
        end
      end
      S_PWR_WAIT:  if (w_cnt_done) w_state_nxt = S_SEQ;
      S_SEQ: begin
        if (r_step == STEP_END) begin
          w_init_nxt      = 1'b0;
          w_init_done_nxt = 1'b1;
          w_blon_nxt      = 1'b1;
          w_state_nxt     = S_DONE;
        end else begin
          w_byte_nxt   = w_seq_byte;
          w_single_nxt = w_seq_single;
          w_exec_nxt   = w_seq_delay;
          w_rs_nxt     = 1'b0;
          w_nib_nxt    = 1'b0;
          w_state_nxt  = S_SETUP;
        end
      end
      S_SETUP:     if (w_cnt_done) w_state_nxt = S_E_HIGH;
      S_E_HIGH:    if (w_cnt_done) w_state_nxt = S_E_LOW;
      S_E_LOW:     if (w_cnt_done) w_state_nxt = S_EXEC_WAIT;
      S_EXEC_WAIT: begin
        if (w_cnt_done) begin
          if (w_gap) begin
            w_nib_nxt   = 1'b1;
            w_state_nxt = S_SETUP;
          end else if (r_init) begin
            w_step_nxt  = w_step_inc;
            w_state_nxt = S_SEQ;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // state, delay counter and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= (AUTO_INIT != 0) ? S_PWR_WAIT : S_IDLE;
      r_cnt       <= '0;
      r_byte      <= '0;
      r_rs        <= 1'b0;
      r_nib       <= 1'b0;
      r_single    <= 1'b0;
      r_exec      <= C_EXEC;
      r_init      <= (AUTO_INIT != 0);
      r_step      <= '0;
      r_err       <= 1'b0;
      r_init_done <= 1'b0;
      r_blon      <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= (w_state_nxt != r_state) ? 32'd0 : r_cnt + 32'd1;
      r_byte      <= w_byte_nxt;
      r_rs        <= w_rs_nxt;
      r_nib       <= w_nib_nxt;
      r_single    <= w_single_nxt;
      r_exec      <= w_exec_nxt;
      r_init      <= w_init_nxt;
      r_step      <= w_step_nxt;
      r_err       <= w_err_nxt;
      r_init_done <= w_init_done_nxt;
      r_blon      <= w_blon_nxt;
      // registered so it stays low in reset even when AUTO_INIT=0 parks us in IDLE
      r_ready     <= (w_state_nxt == S_IDLE) && (w_init_done_nxt || AUTO_INIT == 0);
    end
  end

  assign w_nibble    = r_nib ? r_byte[3:0] : r_byte[7:4];
  assign o_lcd_data  = (BUS_WIDTH == 4) ? {w_nibble, 4'h0} : r_byte;
  assign o_lcd_e     = (r_state == S_E_HIGH);
  assign o_lcd_rs    = r_rs;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_on    = 1'b1;
  assign o_lcd_blon  = r_blon;
  assign o_ready     = r_ready;
  assign o_done      = (r_state == S_DONE);
  assign o_err       = (r_state == S_DONE) && r_err;
  assign o_init_done = r_init_done;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl at a 1 MHz clock: one 8-bit auto-init instance
// and one 4-bit instance that waits for an explicit INIT request.

module tb_lcd_hd44780_ctrl;

  localparam int E_CYC  = 1;
  localparam int T_EXEC = 37;
  localparam int T_CLR  = 1520;
  localparam int T_PWR  = 15000;

  localparam logic [1:0] OP_INIT = 2'd0;
  localparam logic [1:0] OP_SETC = 2'd1;
  localparam logic [1:0] OP_DATA = 2'd2;
  localparam logic [1:0] OP_CMD  = 2'd3;

  typedef struct {
    logic [1:0] op;  logic [7:0] d;  logic [1:0] r;  logic [5:0] c;
    logic err;  int ne;  logic [7:0] b;  logic rs;  int exec;
  } vec_t;

  typedef struct {
    logic done; logic err; int ne; logic [7:0] b0; logic [7:0] b1;
    logic rs; int gap; int lat; int a2d;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       sel, valid, rst_a, rst_b;
  logic [1:0] op, row;
  logic [7:0] data;
  logic [5:0] col;

  logic       ready_a, done_a, err_a, initd_a, e_a, rs_a, rw_a, on_a, blon_a;
  logic       ready_b, done_b, err_b, initd_b, e_b, rs_b, rw_b, on_b, blon_b;
  logic [7:0] lcd_a, lcd_b;
  logic       valid_a, valid_b;

  assign valid_a = valid && !sel;
  assign valid_b = valid && sel;

  lcd_hd44780_ctrl #(.CLK_FREQ(1_000_000), .BUS_WIDTH(8), .NUM_ROWS(2),
                     .NUM_COLS(16), .AUTO_INIT(1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_valid(valid_a), .o_ready(ready_a),
    .i_op(op), .i_data(data), .i_row(row), .i_col(col),
    .o_done(done_a), .o_err(err_a), .o_init_done(initd_a),
    .o_lcd_data(lcd_a), .o_lcd_e(e_a), .o_lcd_rs(rs_a), .o_lcd_rw(rw_a),
    .o_lcd_on(on_a), .o_lcd_blon(blon_a));

  lcd_hd44780_ctrl #(.CLK_FREQ(1_000_000), .BUS_WIDTH(4), .NUM_ROWS(2),
                     .NUM_COLS(16), .AUTO_INIT(0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_b), .i_valid(valid_b), .o_ready(ready_b),
    .i_op(op), .i_data(data), .i_row(row), .i_col(col),
    .o_done(done_b), .o_err(err_b), .o_init_done(initd_b),
    .o_lcd_data(lcd_b), .o_lcd_e(e_b), .o_lcd_rs(rs_b), .o_lcd_rw(rw_b),
    .o_lcd_on(on_b), .o_lcd_blon(blon_b));

  logic       m_ready, m_done, m_err, m_initd, m_e, m_rs, m_rw, m_on, m_blon;
  logic [7:0] m_data;
  assign m_ready = sel ? ready_b : ready_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_err   = sel ? err_b   : err_a;
  assign m_initd = sel ? initd_b : initd_a;
  assign m_e     = sel ? e_b     : e_a;
  assign m_rs    = sel ? rs_b    : rs_a;
  assign m_rw    = sel ? rw_b    : rw_a;
  assign m_on    = sel ? on_b    : on_a;
  assign m_blon  = sel ? blon_b  : blon_a;
  assign m_data  = sel ? lcd_b   : lcd_a;

  int n_vec = 0;
  int n_bad = 0;

  // bus monitor: every E rise is logged, every E pulse width is checked
  logic [7:0] q_bus[$];
  logic       q_rs[$];
  logic       prev_e = 1'b0;
  int         e_w = 0, bad_w = 0, n_done_mon = 0;
  always @(negedge clk) begin
    if (m_e && !prev_e) begin
      q_bus.push_back(m_data);
      q_rs.push_back(m_rs);
    end
    if (m_e) e_w++;
    else begin
      if (prev_e && e_w != E_CYC) bad_w++;
      e_w = 0;
    end
    if (m_done) n_done_mon++;
    prev_e = m_e;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_data"},  {24'h0, m_data}, 32'h0);
    chk({tag, "_e"},     {31'h0, m_e},     32'h0);
    chk({tag, "_rs"},    {31'h0, m_rs},    32'h0);
    chk({tag, "_rw"},    {31'h0, m_rw},    32'h0);
    chk({tag, "_on"},    {31'h0, m_on},    32'h1);
    chk({tag, "_blon"},  {31'h0, m_blon},  32'h0);
    chk({tag, "_ready"}, {31'h0, m_ready}, 32'h0);
    chk({tag, "_done"},  {31'h0, m_done},  32'h0);
    chk({tag, "_err"},   {31'h0, m_err},   32'h0);
    chk({tag, "_initd"}, {31'h0, m_initd}, 32'h0);
  endtask

  // issue one request on the selected DUT and observe it until o_done;
  // with hold=1 i_valid stays high with different operands while busy
  task automatic do_req(input logic [1:0] o, input logic [7:0] d, input logic [1:0] r,
                        input logic [5:0] c, input bit hold, input int budget,
                        output res_t res);
    int t, lowrun;
    logic pe;
    res = '{done: 1'b0, err: 1'b0, ne: 0, b0: 8'h0, b1: 8'h0, rs: 1'b0, gap: 0, lat: 0, a2d: 0};
    t = 0;
    while (!m_ready && t < budget) begin @(negedge clk); t++; end
    chk("req_ready", {31'h0, m_ready}, 32'h1);
    if (!m_ready) return;
    op = o; data = d; row = r; col = c; valid = 1'b1;
    @(posedge clk); #1;
    if (hold) begin op = OP_DATA; data = ~d; row = 2'd0; col = 6'd0; end
    else valid = 1'b0;
    lowrun = 0; pe = 1'b0;
    for (t = 1; t <= budget; t++) begin
      @(negedge clk);
      if (m_done) begin
        res.done = 1'b1; res.err = m_err; res.a2d = t; res.lat = lowrun;
        break;
      end
      if (m_e && !pe) begin
        if (res.ne == 0) begin res.b0 = m_data; res.rs = m_rs; end
        else begin res.b1 = m_data; if (res.ne == 1) res.gap = lowrun; end
        res.ne++;
        lowrun = 0;
      end
      if (!m_e && res.ne > 0) lowrun++;
      pe = m_e;
    end
    valid = 1'b0;
    chk("req_done", {31'h0, res.done}, 32'h1);
  endtask

  vec_t       vecs[11];
  logic [7:0] exp_a[8]  = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  logic [7:0] exp_b[14] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h20, 8'h80, 8'h00,
                            8'h80, 8'h00, 8'h10, 8'h00, 8'h60, 8'h00, 8'hC0};

  initial begin
    #1_500_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    res_t res;
    int   viol, t, qb, db, wb, rs_hi;

    // exec is the busy time after E_LOW; E_LOW itself adds E_CYC
    vecs[0]  = '{OP_DATA, 8'h41, 2'd0, 6'd0,  1'b0, 1, 8'h41, 1'b1, T_EXEC};
    vecs[1]  = '{OP_SETC, 8'h00, 2'd1, 6'd5,  1'b0, 1, 8'hC5, 1'b0, T_EXEC};
    vecs[2]  = '{OP_SETC, 8'h00, 2'd0, 6'd0,  1'b0, 1, 8'h80, 1'b0, T_EXEC};
    vecs[3]  = '{OP_SETC, 8'h00, 2'd1, 6'd15, 1'b0, 1, 8'hCF, 1'b0, T_EXEC};
    vecs[4]  = '{OP_SETC, 8'h00, 2'd2, 6'd0,  1'b1, 0, 8'h00, 1'b0, 0};
    vecs[5]  = '{OP_SETC, 8'h00, 2'd0, 6'd16, 1'b1, 0, 8'h00, 1'b0, 0};
    vecs[6]  = '{OP_SETC, 8'h00, 2'd3, 6'd3,  1'b1, 0, 8'h00, 1'b0, 0};
    vecs[7]  = '{OP_CMD,  8'h01, 2'd0, 6'd0,  1'b0, 1, 8'h01, 1'b0, T_CLR};
    vecs[8]  = '{OP_CMD,  8'h02, 2'd0, 6'd0,  1'b0, 1, 8'h02, 1'b0, T_CLR};
    vecs[9]  = '{OP_CMD,  8'h0E, 2'd0, 6'd0,  1'b0, 1, 8'h0E, 1'b0, T_EXEC};
    vecs[10] = '{OP_DATA, 8'h7E, 2'd0, 6'd0,  1'b0, 1, 8'h7E, 1'b1, T_EXEC};

    sel = 1'b0; valid = 1'b0; op = 2'd0; data = 8'h0; row = 2'd0; col = 6'd0;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst("a_reset");

    // 8-bit auto init
    qb = q_bus.size(); db = n_done_mon; wb = bad_w;
    rst_a = 1'b1;
    viol = 0;
    for (int s = 1; s <= T_PWR; s++) begin
      @(negedge clk);
      if (m_ready || m_e) viol++;
    end
    chk("a_pwr_wait_quiet", viol, 0);
    t = 0;
    while (!m_initd && t < 30000) begin @(negedge clk); t++; end
    chk("a_init_done", {31'h0, m_initd}, 32'h1);
    chk("a_blon", {31'h0, m_blon}, 32'h1);
    chk("a_init_nbytes", q_bus.size() - qb, 8);
    rs_hi = 0;
    for (int k = 0; k < 8; k++)
      if (qb + k < q_bus.size()) begin
        chk($sformatf("a_init_byte%0d", k), {24'h0, q_bus[qb+k]}, {24'h0, exp_a[k]});
        if (q_rs[qb+k]) rs_hi++;
      end
    chk("a_init_rs_low", rs_hi, 0);
    @(negedge clk);
    chk("a_ready_after_init", {31'h0, m_ready}, 32'h1);
    chk("a_init_done_pulses", n_done_mon - db, 1);
    chk("a_init_e_width", bad_w - wb, 0);

    // table of single requests on the 8-bit instance
    wb = bad_w;
    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].op, vecs[i].d, vecs[i].r, vecs[i].c, 1'b0, 5000, res);
      chk($sformatf("v%0d_err", i), {31'h0, res.err}, {31'h0, vecs[i].err});
      chk($sformatf("v%0d_epulses", i), res.ne, vecs[i].ne);
      if (vecs[i].ne > 0) begin
        chk($sformatf("v%0d_byte", i), {24'h0, res.b0}, {24'h0, vecs[i].b});
        chk($sformatf("v%0d_rs", i), {31'h0, res.rs}, {31'h0, vecs[i].rs});
        chk($sformatf("v%0d_fall_to_done", i), res.lat, E_CYC + vecs[i].exec);
      end else begin
        chk($sformatf("v%0d_accept_to_done", i), res.a2d, 1);
      end
    end
    chk("a_vec_e_width", bad_w - wb, 0);

    // i_valid held with other data while busy must not start a second write
    qb = q_bus.size();
    do_req(OP_DATA, 8'h41, 2'd0, 6'd0, 1'b1, 5000, res);
    chk("a_hold_byte", {24'h0, res.b0}, 32'h41);
    chk("a_hold_fall_to_done", res.lat, E_CYC + T_EXEC);
    repeat (20) @(negedge clk);
    chk("a_hold_single_write", q_bus.size() - qb, 1);

    // 4-bit instance, no auto init
    sel = 1'b1;
    @(negedge clk);
    chk_rst("b_reset");
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("b_ready_uninit", {31'h0, m_ready}, 32'h1);
    qb = q_bus.size();
    do_req(OP_DATA, 8'h33, 2'd0, 6'd0, 1'b0, 100, res);
    chk("b_data_uninit_err", {31'h0, res.err}, 32'h1);
    chk("b_data_uninit_a2d", res.a2d, 1);
    do_req(OP_CMD, 8'h01, 2'd0, 6'd0, 1'b0, 100, res);
    chk("b_cmd_uninit_err", {31'h0, res.err}, 32'h1);
    chk("b_uninit_no_e", q_bus.size() - qb, 0);

    qb = q_bus.size(); wb = bad_w;
    do_req(OP_INIT, 8'h00, 2'd0, 6'd0, 1'b0, 30000, res);
    chk("b_init_err", {31'h0, res.err}, 32'h0);
    chk("b_init_done", {31'h0, m_initd}, 32'h1);
    chk("b_init_blon", {31'h0, m_blon}, 32'h1);
    chk("b_init_nwrites", q_bus.size() - qb, 14);
    for (int k = 0; k < 14; k++)
      if (qb + k < q_bus.size())
        chk($sformatf("b_init_nib%0d", k), {24'h0, q_bus[qb+k]}, {24'h0, exp_b[k]});

    // gap = E_LOW + T_NIB + SETUP of the second nibble
    do_req(OP_DATA, 8'h5A, 2'd0, 6'd0, 1'b0, 5000, res);
    chk("b_data_epulses", res.ne, 2);
    chk("b_data_hi", {24'h0, res.b0}, 32'h50);
    chk("b_data_lo", {24'h0, res.b1}, 32'hA0);
    chk("b_data_rs", {31'h0, res.rs}, 32'h1);
    chk("b_data_gap", res.gap, E_CYC + 1 + E_CYC);
    chk("b_data_fall_to_done", res.lat, E_CYC + T_EXEC);
    do_req(OP_SETC, 8'h00, 2'd1, 6'd3, 1'b0, 5000, res);
    chk("b_setc_hi", {24'h0, res.b0}, 32'hC0);
    chk("b_setc_lo", {24'h0, res.b1}, 32'h30);
    chk("b_e_width", bad_w - wb, 0);

    // re-INIT clears init_done; reset asserted while E is high
    t = 0;
    while (!m_ready && t < 100) begin @(negedge clk); t++; end
    op = OP_INIT; valid = 1'b1;
    @(posedge clk); #1 valid = 1'b0;
    @(negedge clk);
    chk("b_reinit_clears", {31'h0, m_initd}, 32'h0);
    chk("b_reinit_busy", {31'h0, m_ready}, 32'h0);
    qb = q_bus.size();
    t = 0;
    while ((q_bus.size() - qb < 3 || !m_e) && t < 30000) begin @(negedge clk); t++; end
    chk("b_reinit_e_high", {31'h0, m_e}, 32'h1);
    #2 rst_b = 1'b0;
    #1 chk_rst("b_midreset");
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("b_after_rst_ready", {31'h0, m_ready}, 32'h1);
    do_req(OP_DATA, 8'h21, 2'd0, 6'd0, 1'b0, 100, res);
    chk("b_after_rst_reject", {31'h0, res.err}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
